// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state codes,
// opcode constants, datapath select encodings and the decoded control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RD1    = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // fetch marks the state whose IR/PC strobes are qualified by mem_ready;
    // pc_update is the unconditional PC write used by JAL.
    typedef struct packed {
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Combinational state -> control-word decode for the multi-cycle sequencer.
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t ctrl
);

    // Moore decode: every field defaults to 0, each state sets only what it uses
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.fetch      = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURES;
            end
            S_DECODE: begin
                // Branch target is computed here and parked in ALUOut
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_FUNCT;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control sequencer of the multi-cycle RISC-V core. Optional performance
// counters (cycle_cnt, instret_cnt) are built when MC_CTRL_PERF_EN is defined.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 7
`ifdef MC_CTRL_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [OP_W-1:0] op,
    input  logic            funct3_0,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            adr_src,
    output logic            mem_write,
    output logic            ir_write,
    output logic [1:0]      result_src,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            reg_write,
    output logic            illegal_op
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);

    state_t     state_r;
    state_t     next_state_s;
    ctrl_word_t ctrl_s;
    logic       decode_illegal_s;
    logic       take_branch_s;

    mc_ctrl_out_decode u_out_decode (
        .state (state_r),
        .ctrl  (ctrl_s)
    );

    // Next-state selection; unreachable codes fall back to FETCH
    always_comb begin
        next_state_s     = S_FETCH;
        decode_illegal_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_R:         next_state_s = S_EXECR;
                    OP_I:         next_state_s = S_EXECI;
                    OP_JAL:       next_state_s = S_JAL;
                    OP_BRANCH:    next_state_s = S_BRANCH;
                    default: begin
                        next_state_s     = S_FETCH;
                        decode_illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    next_state_s = S_MEMREAD;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_EXECR:  next_state_s = S_ALUWB;
            S_EXECI:  next_state_s = S_ALUWB;
            S_JAL:    next_state_s = S_ALUWB;
            S_MEMWB:  next_state_s = S_FETCH;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // State register, async-cleared to FETCH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Strobes are gated by resetn so nothing writes while reset is held,
    // even though FETCH would otherwise follow mem_ready.
    always_comb begin
        take_branch_s = ctrl_s.branch & (zero ^ funct3_0);
        pc_write      = resetn & ((ctrl_s.fetch & mem_ready) | ctrl_s.pc_update | take_branch_s);
        ir_write      = resetn & ctrl_s.fetch & mem_ready;
        mem_write     = resetn & ctrl_s.mem_write;
        reg_write     = resetn & ctrl_s.reg_write;
        illegal_op    = resetn & decode_illegal_s;
        adr_src       = ctrl_s.adr_src;
        result_src    = ctrl_s.result_src;
        alu_src_a     = ctrl_s.alu_src_a;
        alu_src_b     = ctrl_s.alu_src_b;
        alu_op        = ctrl_s.alu_op;
    end

`ifdef MC_CTRL_PERF_EN
    logic retire_s;

    // An instruction retires on its final edge back into FETCH; illegal returns excluded
    always_comb begin
        case (state_r)
            S_MEMWB, S_ALUWB, S_BRANCH: retire_s = 1'b1;
            S_MEMWRITE:                 retire_s = mem_ready;
            default:                    retire_s = 1'b0;
        endcase
    end

    // Free-running cycle and retired-instruction counters, wrapping naturally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + PERF_W'(1);
            if (retire_s) begin
                instret_cnt <= instret_cnt + PERF_W'(1);
            end else begin
                instret_cnt <= instret_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction expected cycle
// sequences are built from the instruction class and the memory wait pattern.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] op;
    logic       funct3_0;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
    int          cyc_m;
`endif

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .resetn(resetn), .op(op), .funct3_0(funct3_0), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .illegal_op(illegal_op)
`ifdef MC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

`ifdef MC_CTRL_PERF_EN
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc_m <= 0;
        else         cyc_m <= cyc_m + 1;
    end
`endif

    typedef struct packed {
        logic        mr;
        logic        zr;
        logic [13:0] exp;
        logic        ret;
        logic [3:0]  ph;
    } step_t;

    step_t      q[$];
    int         total = 0;
    int         bad = 0;
    int         instret_m = 0;
    logic [6:0] cur_op;
    logic       cur_f3;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;

    // Output vector order: pc_write adr mem_write ir_write res[2] a[2] b[2] aluop[2] reg_write illegal
    function automatic logic [13:0] ow(input int pcw, input int adr, input int mw, input int irw,
                                       input int res, input int a, input int b, input int aop,
                                       input int rw, input int ill);
        return {pcw[0], adr[0], mw[0], irw[0], res[1:0], a[1:0], b[1:0], aop[1:0], rw[0], ill[0]};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BR);
    endfunction

    task automatic push(input logic mr, input logic zr, input logic [13:0] e, input logic ret, input int ph);
        step_t s;
        s.mr = mr; s.zr = zr; s.exp = e; s.ret = ret; s.ph = 4'(ph);
        q.push_back(s);
    endtask

    // zsel < 0: random zero flag for the branch cycle, otherwise forced to zsel
    task automatic build(input logic [6:0] o, input logic f3, input int fw, input int mw, input int zsel);
        logic z;
        cur_op = o;
        cur_f3 = f3;
        for (int i = 0; i < fw; i++) push(1'b0, rb(), ow(0,0,0,0,2,0,2,0,0,0), 1'b0, 0);
        push(1'b1, rb(), ow(1,0,0,1,2,0,2,0,0,0), 1'b0, 0);
        push(rb(), rb(), ow(0,0,0,0,0,1,1,0,0, is_legal(o) ? 0 : 1), 1'b0, 1);
        if (o == LW || o == SW) begin
            push(rb(), rb(), ow(0,0,0,0,0,2,1,0,0,0), 1'b0, 2);
            for (int i = 0; i < mw; i++)
                push(1'b0, rb(), (o == LW) ? ow(0,1,0,0,0,0,0,0,0,0) : ow(0,1,1,0,0,0,0,0,0,0), 1'b0, (o == LW) ? 3 : 5);
            if (o == LW) begin
                push(1'b1, rb(), ow(0,1,0,0,0,0,0,0,0,0), 1'b0, 3);
                push(rb(), rb(), ow(0,0,0,0,1,0,0,0,1,0), 1'b1, 4);
            end else begin
                push(1'b1, rb(), ow(0,1,1,0,0,0,0,0,0,0), 1'b1, 5);
            end
        end else if (o == RT || o == IT || o == JL) begin
            if (o == RT)      push(rb(), rb(), ow(0,0,0,0,0,2,0,2,0,0), 1'b0, 6);
            else if (o == IT) push(rb(), rb(), ow(0,0,0,0,0,2,1,2,0,0), 1'b0, 7);
            else              push(rb(), rb(), ow(1,0,0,0,0,1,2,0,0,0), 1'b0, 8);
            push(rb(), rb(), ow(0,0,0,0,0,0,0,0,1,0), 1'b1, 9);
        end else if (o == BR) begin
            z = (zsel < 0) ? rb() : zsel[0];
            push(rb(), z, ow((z ^ f3) ? 1 : 0,0,0,0,0,2,0,1,0,0), 1'b1, 10);
        end
    endtask

    task automatic exec_q(input int limit, input string name);
        int          n = 0;
        step_t       s;
        logic [13:0] act;
        while (q.size() > 0) begin
            s = q.pop_front();
            if (n >= limit) continue;
            @(negedge clk);
            op = cur_op; funct3_0 = cur_f3; mem_ready = s.mr; zero = s.zr;
            #1;
            act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal_op};
            total++;
            if (act !== s.exp) begin
                bad++;
                $display("FAIL %s step%0d phase%0d: got %b want %b", name, n, s.ph, act, s.exp);
            end
            @(posedge clk);
            if (s.ret) instret_m++;
            n++;
        end
`ifdef MC_CTRL_PERF_EN
        #1;
        total++;
        if (instret_cnt !== 32'(instret_m)) begin
            bad++;
            $display("FAIL %s instret: got %0d want %0d", name, instret_cnt, instret_m);
        end
        total++;
        if (cycle_cnt !== 32'(cyc_m)) begin
            bad++;
            $display("FAIL %s cycles: got %0d want %0d", name, cycle_cnt, cyc_m);
        end
`endif
    endtask

    task automatic check_in_reset(input string name);
        logic [13:0] act;
        act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal_op};
        total++;
        if (act !== ow(0,0,0,0,2,0,2,0,0,0)) begin
            bad++;
            $display("FAIL %s outputs: got %b want %b", name, act, ow(0,0,0,0,2,0,2,0,0,0));
        end
`ifdef MC_CTRL_PERF_EN
        total++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            bad++;
            $display("FAIL %s counters: got %0d/%0d want 0/0", name, cycle_cnt, instret_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        resetn = 1'b0; mem_ready = 1'b1; op = RT; funct3_0 = 1'b0; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_in_reset("reset");
        instret_m = 0;
        @(negedge clk);
        mem_ready = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic test_rtype();
        build(RT, 1'b0, 0, 0, -1);
        exec_q(1000, "rtype");
    endtask

    task automatic test_load_wait();
        build(LW, 1'b0, 0, 2, -1);
        exec_q(1000, "load_wait");
    endtask

    task automatic test_store();
        build(SW, 1'b0, 0, 1, -1);
        exec_q(1000, "store");
    endtask

    task automatic test_branch();
        build(BR, 1'b0, 0, 0, 1); exec_q(1000, "beq_taken");
        build(BR, 1'b0, 0, 0, 0); exec_q(1000, "beq_not_taken");
        build(BR, 1'b1, 0, 0, 0); exec_q(1000, "bne_taken");
        build(BR, 1'b1, 1, 0, 1); exec_q(1000, "bne_not_taken");
    endtask

    task automatic test_illegal();
        build(7'b1111111, 1'b0, 0, 0, -1); exec_q(1000, "illegal");
        build(7'b0000000, 1'b1, 1, 0, -1); exec_q(1000, "illegal_zero");
    endtask

    task automatic test_reset_mid_op();
        build(SW, 1'b0, 0, 3, -1);
        exec_q(4, "rst_mid_pre");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (mem_write !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_hold mem_write: got %b want 1", mem_write);
        end
        resetn = 1'b0;
        #1;
        mem_ready = 1'b1;
        #1;
        check_in_reset("rst_mid");
        instret_m = 0;
        @(negedge clk);
        mem_ready = 1'b0;
        resetn = 1'b1;
        build(LW, 1'b0, 0, 0, -1); exec_q(1000, "after_rst_lw");
        build(SW, 1'b0, 0, 0, -1); exec_q(1000, "after_rst_sw");
        build(RT, 1'b0, 0, 0, -1); exec_q(1000, "after_rst_r");
    endtask

    task automatic test_back_to_back();
        logic [6:0] legal_ops [6];
        logic [6:0] o;
        legal_ops = '{LW, SW, RT, IT, JL, BR};
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                do o = 7'($urandom_range(0, 127)); while (is_legal(o));
            end else begin
                o = legal_ops[$urandom_range(0, 5)];
            end
            build(o, rb(), $urandom_range(0, 2), $urandom_range(0, 2), -1);
            exec_q(1000, "random");
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branch();
        test_illegal();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control sequencer for the multi-cycle RISC-V core.
- Walks each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select (address, ALU operand A/B, result) plus the register, IR, PC and memory write enables.
- Stalls on a memory ready handshake; sits between the instruction register decode fields and the shared datapath.

Parameters:
- OP_W, 7, opcode field width.
- PERF_W, 32, performance counter width; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- op  in  OP_W  opcode from instruction register.
- funct3_0  in  1  instr[12]: 0 = beq, 1 = bne.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = result.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR/OldPC enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  ALU operand B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct decode.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
  - State register is async-cleared to FETCH.
  - While resetn = 0, pc_write, ir_write, mem_write, reg_write and illegal_op are forced to 0.
  - Select outputs show FETCH values.
- Output style: Moore outputs decoded from state. ir_write, FETCH pc_update and mem_write progression are qualified by mem_ready.
- PC write: pc_write = pc_update | (branch & (zero ^ funct3_0)).
- FETCH: adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - ir_write = pc_update = mem_ready.
  - Hold while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1101111 -> JAL.
  - 1100011 -> BRANCH.
  - Anything else -> FETCH with illegal_op = 1 for this cycle.
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Next is MEMREAD if op = 0000011, otherwise MEMWRITE.
- MEMREAD: adr_src = 1, result_src = 00. Hold until mem_ready, then MEMWB.
- MEMWB: result_src = 01, reg_write = 1. Next is FETCH.
- MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1.
  - mem_write stays asserted and stable until mem_ready, then FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Next is ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10. Next is ALUWB.
- JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_update = 1. Next is ALUWB.
- ALUWB: result_src = 00, reg_write = 1. Next is FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, branch = 1. Next is FETCH.
- Unlisted outputs are 0 in each state.
- Latency with zero-wait memory: beq = 3 cycles; R/I/sw/jal = 4; lw = 5. Each mem_ready = 0 cycle adds one cycle.
- mem_ready in a non-memory state is ignored.
- Reset asserted mid-instruction: immediate return to FETCH and all strobes drop; no partial writeback.
- Encoding: state is 4-bit binary. Unreachable codes recover to FETCH on the next edge.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- When defined, adds two outputs, cycle_cnt (PERF_W) and instret_cnt (PERF_W). Both async-clear to 0.
- cycle_cnt increments every clock.
- instret_cnt increments on each transition into FETCH from MEMWB, ALUWB, BRANCH or MEMWRITE (the last only on its mem_ready cycle).
  - Illegal-opcode returns do not count.
  - Both counters wrap modulo 2^PERF_W.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state codes;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BRANCH);
  - select encodings (SRCA_*, SRCB_*, RES_*, ALUOP_*).
- One sub-module, mc_ctrl_out_decode: purely combinational state -> control-word decode. The top keeps the state register, next-state logic, pc_write and the counters.

Test Plan:
- Reset and fetch: release resetn, mem_ready = 1, op = 0110011 -> states FETCH, DECODE, EXECR, ALUWB, FETCH. reg_write = 1 only in cycle 4; pc_write = 1 only in cycle 1.
- Load with wait states: op = 0000011, mem_ready low for 2 cycles in MEMREAD.
  - MEMREAD is held 3 cycles with adr_src = 1.
  - MEMWB then follows with result_src = 01, reg_write = 1.
  - Total 7 cycles.
- Store: op = 0100011, mem_ready = 0 for 1 cycle -> mem_write = 1 for exactly 2 cycles, then FETCH.
- Branch: op = 1100011 with funct3_0 = 0 and zero = 1 -> pc_write = 1 in BRANCH. With zero = 0 -> pc_write = 0. With funct3_0 = 1 and zero = 0 -> pc_write = 1.
- Illegal opcode: op = 1111111 -> illegal_op pulses in DECODE, next state FETCH, no reg_write or mem_write.
- Async reset mid-op: pull resetn low during MEMWRITE -> mem_write drops the same cycle and the state is FETCH after release. With MC_CTRL_PERF_EN, instret_cnt = 0 and it increments after 3 completed instructions to 3.
